// File: rtl/uart_rx_if.sv
// Serial-line input and received-word outputs of uart_rx.
// The slave side is the receiver; the master side drives the line and consumes words.
interface uart_rx_if #(
  parameter int N = 8
);
  logic         i_rx;
  logic [N-1:0] o_data;
  logic         o_dv;
  logic         o_busy;
  logic         o_frame_err;
  logic         o_parity_err;

  modport slave  (input i_rx, output o_data, o_dv, o_busy, o_frame_err, o_parity_err);
  modport master (output i_rx, input o_data, o_dv, o_busy, o_frame_err, o_parity_err);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised line, mid-bit sampling, LSB-first data, optional parity,
// one stop bit; each word or framing error is reported as a single-cycle pulse.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BR       = 9600,
  parameter int N        = 8,
  parameter int PARITY   = 0
) (
  input  logic     i_clk,
  input  logic     rst_n,
  uart_rx_if.slave rx_if
);
  localparam int CPB  = CLK_FREQ / BR;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int IW   = $clog2(N);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic          ODD      = (PARITY == 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic          rx_meta_reg;
  logic          rx_s_reg;
  logic          rx_prev_reg;
  logic [2:0]    state_reg;
  logic [2:0]    state_next;
  logic [CW-1:0] clk_cnt_reg;
  logic [IW-1:0] idx_reg;
  logic [N-1:0]  data_sh_reg;
  logic [N-1:0]  bit_we;
  logic          par_err_reg;
  logic [N-1:0]  data_reg;
  logic          dv_reg;
  logic          busy_reg;
  logic          frame_err_reg;
  logic          parity_err_reg;

  logic fall;
  logic at_half;
  logic at_last;
  logic data_sample;
  logic par_sample;
  logic stop_sample;

  assign fall        = rx_prev_reg & ~rx_s_reg;
  assign at_half     = (clk_cnt_reg == CNT_HALF);
  assign at_last     = (clk_cnt_reg == CNT_LAST);
  assign data_sample = (state_reg == S_DATA)   && at_last;
  assign par_sample  = (state_reg == S_PARITY) && at_last;
  assign stop_sample = (state_reg == S_STOP)   && at_last;

  // One write enable per data bit; only the bit addressed by idx_reg captures the sample.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit_we
    assign bit_we[gi] = data_sample && (idx_reg == IW'(gi));
  end

  // Synchroniser and edge history idle high so a low line at reset release is not a start.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx_if.i_rx;
      rx_s_reg    <= rx_meta_reg;
      rx_prev_reg <= rx_s_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (fall)    state_next = S_START;
      S_START:  if (at_half) state_next = rx_s_reg ? S_IDLE : S_DATA;
      S_DATA:   if (at_last && (idx_reg == IDX_LAST))
                  state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (at_last) state_next = S_STOP;
      S_STOP:   if (at_last) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      clk_cnt_reg    <= '0;
      idx_reg        <= '0;
      data_sh_reg    <= '0;
      par_err_reg    <= 1'b0;
      data_reg       <= '0;
      dv_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      busy_reg       <= (state_next != S_IDLE);
      dv_reg         <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;

      if ((state_next != state_reg) || data_sample || (state_reg == S_IDLE))
        clk_cnt_reg <= '0;
      else
        clk_cnt_reg <= clk_cnt_reg + 1'b1;

      if (state_reg == S_START) begin
        idx_reg     <= '0;
        par_err_reg <= 1'b0;
      end else if (data_sample) begin
        idx_reg <= idx_reg + 1'b1;
      end

      data_sh_reg <= (data_sh_reg & ~bit_we) | ({N{rx_s_reg}} & bit_we);

      if (par_sample)
        par_err_reg <= (((^data_sh_reg) ^ rx_s_reg) != ODD);

      // A low stop bit discards the word entirely: o_data keeps the previous good value.
      if (stop_sample) begin
        if (rx_s_reg) begin
          data_reg       <= data_sh_reg;
          dv_reg         <= 1'b1;
          parity_err_reg <= par_err_reg;
        end else begin
          frame_err_reg  <= 1'b1;
        end
      end
    end
  end

  assign rx_if.o_data       = data_reg;
  assign rx_if.o_dv         = dv_reg;
  assign rx_if.o_busy       = busy_reg;
  assign rx_if.o_frame_err  = frame_err_reg;
  assign rx_if.o_parity_err = parity_err_reg;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three receivers (no / odd / even parity) share one serial line and are
// checked against a frame-level model of word, error flags and output latency.
module tb_uart_rx;
  localparam int CPB  = 10;
  localparam int HALF = 5;

  logic i_clk = 1'b0;
  logic rst_n;
  logic rx_line;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  uart_rx_if #(.N(8)) bus_n ();
  uart_rx_if #(.N(8)) bus_o ();
  uart_rx_if #(.N(8)) bus_e ();
  assign bus_n.i_rx = rx_line;
  assign bus_o.i_rx = rx_line;
  assign bus_e.i_rx = rx_line;

  uart_rx #(.CLK_FREQ(1_000_000), .BR(100_000), .N(8), .PARITY(0)) dut_n (
    .i_clk(i_clk), .rst_n(rst_n), .rx_if(bus_n.slave));
  uart_rx #(.CLK_FREQ(1_000_000), .BR(100_000), .N(8), .PARITY(1)) dut_o (
    .i_clk(i_clk), .rst_n(rst_n), .rx_if(bus_o.slave));
  uart_rx #(.CLK_FREQ(1_000_000), .BR(100_000), .N(8), .PARITY(2)) dut_e (
    .i_clk(i_clk), .rst_n(rst_n), .rx_if(bus_e.slave));

  // Index 0/1/2 equals the PARITY setting of the receiver.
  logic [2:0] dv_w, fe_w, pe_w, busy_w;
  logic [7:0] data_w [3];
  assign dv_w     = {bus_e.o_dv,         bus_o.o_dv,         bus_n.o_dv};
  assign fe_w     = {bus_e.o_frame_err,  bus_o.o_frame_err,  bus_n.o_frame_err};
  assign pe_w     = {bus_e.o_parity_err, bus_o.o_parity_err, bus_n.o_parity_err};
  assign busy_w   = {bus_e.o_busy,       bus_o.o_busy,       bus_n.o_busy};
  assign data_w[0] = bus_n.o_data;
  assign data_w[1] = bus_o.o_data;
  assign data_w[2] = bus_e.o_data;

  int         dv_cnt  [3] = '{default: 0};
  int         fe_cnt  [3] = '{default: 0};
  int         hi_cnt  [3] = '{default: 0};
  int         low_cnt [3] = '{default: 0};
  int         fe_time [3] = '{default: 0};
  int         pe_stray    = 0;
  int         dv_time [3][64];
  int         dv_low  [3][64];
  logic [7:0] dv_data [3][64];
  logic       dv_perr [3][64];

  always @(negedge i_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dv_w[i]) begin
        dv_time[i][dv_cnt[i] % 64] <= cyc;
        dv_data[i][dv_cnt[i] % 64] <= data_w[i];
        dv_perr[i][dv_cnt[i] % 64] <= pe_w[i];
        dv_low[i][dv_cnt[i] % 64]  <= low_cnt[i];
        dv_cnt[i] <= dv_cnt[i] + 1;
      end
      if (fe_w[i]) begin
        fe_time[i] <= cyc;
        fe_cnt[i]  <= fe_cnt[i] + 1;
      end
      if (pe_w[i] && !dv_w[i]) pe_stray <= pe_stray + 1;
      if (busy_w[i]) hi_cnt[i] <= hi_cnt[i] + 1;
      else           low_cnt[i] <= low_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: parity error means the ones count (data + parity bit) has the wrong sense.
  function automatic logic model_perr(input logic [7:0] d, input logic pbit, input int mode);
    int ones;
    ones = int'(pbit);
    for (int k = 0; k < 8; k++) ones += int'(d[k]);
    if (mode == 1) return (ones % 2) == 0;
    if (mode == 2) return (ones % 2) == 1;
    return 1'b0;
  endfunction

  // Line fall to output pulse: 2 sync + 1 edge detect + half bit + data/parity bits + stop bit.
  function automatic int model_latency(input int mode);
    return 3 + HALF + (8 + ((mode != 0) ? 1 : 0)) * CPB + CPB;
  endfunction

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic stop, input int extra_low, output int t0);
    rx_line = 1'b0;
    t0 = cyc;
    repeat (CPB) @(negedge i_clk);
    for (int k = 0; k < 8; k++) begin
      rx_line = d[k];
      repeat (CPB) @(negedge i_clk);
    end
    if (has_par) begin
      rx_line = pbit;
      repeat (CPB) @(negedge i_clk);
    end
    rx_line = stop;
    repeat (CPB + (stop ? 0 : extra_low)) @(negedge i_clk);
    rx_line = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input int i, input int dv0, input int fe0,
                              input int t0, input logic [7:0] d, input logic pbit,
                              input logic stop, input logic [7:0] prev);
    int k;
    k = dv0 % 64;
    if (stop) begin
      check({tag, "_ndv"}, dv_cnt[i] - dv0, 1);
      check({tag, "_nfe"}, fe_cnt[i] - fe0, 0);
      if (dv_cnt[i] > dv0) begin
        check({tag, "_data"}, dv_data[i][k], d);
        check({tag, "_lat"},  dv_time[i][k] - t0, model_latency(i));
        check({tag, "_perr"}, dv_perr[i][k], model_perr(d, pbit, i));
      end
    end else begin
      check({tag, "_ndv"}, dv_cnt[i] - dv0, 0);
      check({tag, "_nfe"}, fe_cnt[i] - fe0, 1);
      if (fe_cnt[i] > fe0) check({tag, "_felat"}, fe_time[i] - t0, model_latency(i));
    end
    check({tag, "_word"}, data_w[i], stop ? d : prev);
  endtask

  initial begin
    int          t0, dv0, fe0, hi0, k0, gap;
    int          dv0_p [3];
    int          fe0_p [3];
    logic [7:0]  d, last_n;
    logic [7:0]  last_p [3];
    logic        pbit, stop;
    string       tag;

    rst_n   = 1'b0;
    rx_line = 1'b1;
    repeat (4) @(negedge i_clk);
    check("rst_dv",   dv_w,   3'b000);
    check("rst_busy", busy_w, 3'b000);
    check("rst_fe",   fe_w,   3'b000);
    check("rst_pe",   pe_w,   3'b000);
    check("rst_data", data_w[0], 8'h00);
    rst_n = 1'b1;
    idle(2 * CPB);
    check("idle_busy", busy_w, 3'b000);
    check("idle_ndv",  dv_cnt[0], 0);

    // Single frame, exact latency
    dv0 = dv_cnt[0]; fe0 = fe_cnt[0];
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0, t0);
    $display("frame t1 data=a5 stop=1");
    expect_frame("t1", 0, dv0, fe0, t0, 8'hA5, 1'b0, 1'b1, 8'h00);
    idle(3 * CPB);

    // Back-to-back frames with no idle gap
    k0 = dv_cnt[0];
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 8'h00 : 8'hFF;
      dv0 = dv_cnt[0]; fe0 = fe_cnt[0];
      send_frame(d, 1'b0, 1'b0, 1'b1, 0, t0);
      $display("frame t2_%0d data=%02h stop=1", k, d);
      expect_frame($sformatf("t2_%0d", k), 0, dv0, fe0, t0, d, 1'b0, 1'b1, 8'h00);
    end
    last_n = 8'hFF;
    gap = dv_low[0][(k0 + 1) % 64] - dv_low[0][k0 % 64];
    check("t2_busy_gap", (gap >= 1) && (gap <= CPB), 1'b1);
    idle(2 * CPB);

    // Short glitch: busy pulses, nothing reported
    dv0 = dv_cnt[0]; fe0 = fe_cnt[0]; hi0 = hi_cnt[0];
    rx_line = 1'b0;
    repeat (3) @(negedge i_clk);
    idle(3 * CPB);
    $display("frame t3 glitch 3 clks");
    check("t3_ndv",  dv_cnt[0] - dv0, 0);
    check("t3_nfe",  fe_cnt[0] - fe0, 0);
    check("t3_busy_seen", (hi_cnt[0] - hi0) > 0, 1'b1);
    check("t3_busy_end",  busy_w[0], 1'b0);

    // Stop bit low, line held low afterwards
    dv0 = dv_cnt[0]; fe0 = fe_cnt[0];
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 30, t0);
    $display("frame t4 data=3c stop=0 held low");
    expect_frame("t4", 0, dv0, fe0, t0, 8'h3C, 1'b0, 1'b0, last_n);
    idle(3 * CPB);
    check("t4_fe_once", fe_cnt[0] - fe0, 1);

    // Reset in the middle of data bit 4, then a clean frame
    dv0 = dv_cnt[0];
    d = 8'h55;
    rx_line = 1'b0;
    repeat (CPB) @(negedge i_clk);
    for (int k = 0; k < 4; k++) begin
      rx_line = d[k];
      repeat (CPB) @(negedge i_clk);
    end
    rx_line = d[4];
    repeat (HALF) @(negedge i_clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy_w, 3'b000);
    check("t6_rst_data", data_w[0], 8'h00);
    repeat (3) @(negedge i_clk);
    rx_line = 1'b1;
    rst_n = 1'b1;
    idle(2 * CPB);
    fe0 = fe_cnt[0];
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 0, t0);
    $display("frame t6 data=81 after mid-frame reset");
    expect_frame("t6", 0, dv0, fe0, t0, 8'h81, 1'b0, 1'b1, 8'h00);
    last_n = 8'h81;
    idle(2 * CPB);

    // Random frames without parity
    for (int k = 0; k < 16; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      dv0 = dv_cnt[0]; fe0 = fe_cnt[0];
      send_frame(d, 1'b0, 1'b0, stop, 0, t0);
      tag = $sformatf("rn%0d", k);
      $display("frame %s data=%02h stop=%0d", tag, d, stop);
      expect_frame(tag, 0, dv0, fe0, t0, d, 1'b0, stop, last_n);
      if (stop) last_n = d;
      gap = stop ? (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20))
                 : $urandom_range(CPB, 2 * CPB);
      if (gap > 0) idle(gap);
    end

    // Parity receivers start from a clean reset
    idle(15 * CPB);
    rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    rst_n = 1'b1;
    idle(2 * CPB);
    last_p[1] = 8'h00;
    last_p[2] = 8'h00;

    for (int k = 0; k < 18; k++) begin
      if (k < 2) begin
        d = 8'h07; pbit = (k == 1); stop = 1'b1;
      end else begin
        d    = 8'($urandom);
        pbit = 1'($urandom);
        stop = ($urandom_range(0, 4) != 0);
      end
      for (int i = 1; i < 3; i++) begin
        dv0_p[i] = dv_cnt[i];
        fe0_p[i] = fe_cnt[i];
      end
      send_frame(d, 1'b1, pbit, stop, 0, t0);
      tag = (k < 2) ? $sformatf("t5_%0d", k) : $sformatf("rp%0d", k);
      $display("frame %s data=%02h pbit=%0d stop=%0d", tag, d, pbit, stop);
      for (int i = 1; i < 3; i++) begin
        expect_frame($sformatf("%s_p%0d", tag, i), i, dv0_p[i], fe0_p[i], t0, d, pbit, stop,
                     last_p[i]);
        if (stop) last_p[i] = d;
      end
      gap = stop ? (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20))
                 : $urandom_range(CPB, 2 * CPB);
      if (gap > 0) idle(gap);
    end

    idle(2 * CPB);
    check("pe_only_with_dv", pe_stray, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
